// File: rtl/reverb_key_pio_in_if.sv
// reverb_key_pio_in_if: Avalon-MM slave bus bundle for the key/switch input PIO
//   address/chipselect/write_n/writedata : master -> slave
//   readdata (zero-extended), irq        : slave -> master
interface reverb_key_pio_in_if;
  logic [1:0] address;
  logic chipselect;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic irq;
  modport master(output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave(input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/reverb_key_pio_in.sv
// reverb_key_pio_in: synchronised, debounced KEY/SW input PIO with edge capture and maskable IRQ
//   clk, reset_n : clock, synchronous active-low reset
//   in_port      : asynchronous board inputs
//   bus          : Avalon-MM slave (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP W1C), level irq
module reverb_key_pio_in #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int IDLE_LEVEL = 1,
  parameter int EDGE_TYPE = 1
) (
  input logic clk,
  input logic reset_n,
  input logic [WIDTH-1:0] in_port,
  reverb_key_pio_in_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE = {WIDTH{1'(IDLE_LEVEL)}};
  logic [WIDTH-1:0] s1, s2, deb, deb_nx, mask, cap, ev, clr;
  logic wr, unused_ok;
  always_ff @(posedge clk)
    if (!reset_n) begin
      s1 <= IDLE;
      s2 <= IDLE;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    logic [CW-1:0] cnt;
    assign deb_nx[i] = (s2[i] != deb[i] && cnt == LAST) ? s2[i] : deb[i];
    // any return to the debounced level mid-count restarts the window
    always_ff @(posedge clk)
      if (!reset_n) cnt <= '0;
      else cnt <= (s2[i] == deb[i] || cnt == LAST) ? '0 : cnt + 1'b1;
  end
  assign ev = EDGE_TYPE == 0 ? ~deb & deb_nx :
              EDGE_TYPE == 1 ? deb & ~deb_nx : deb ^ deb_nx;
  assign wr = bus.chipselect & ~bus.write_n;
  assign clr = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
  // a capture arriving on the same edge as its W1C clear survives
  always_ff @(posedge clk)
    if (!reset_n) begin
      deb <= IDLE;
      mask <= '0;
      cap <= '0;
    end else begin
      deb <= deb_nx;
      cap <= (cap & ~clr) | ev;
      if (wr && bus.address == 2'd2) mask <= bus.writedata[WIDTH-1:0];
    end
  assign bus.readdata = bus.address == 2'd0 ? 32'(deb) :
                        bus.address == 2'd2 ? 32'(mask) :
                        bus.address == 2'd3 ? 32'(cap) : '0;
  assign bus.irq = |(cap & mask);
  assign unused_ok = ^bus.writedata;
endmodule
